mips_ras: RTL

- Parametrised return-address stack (RAS) predicting JR $31 / JALR return targets in the IF stage of the MIPS pipeline.
- IF pushes PC+4 on JAL/JALR (call) and pops on JR $31 (return); the popped top-of-stack supplies the predicted next PC.
- ID resolves the jump one cycle later. A squash from ID undoes the most recent speculative stack operation, so wrong-path fetches never corrupt the stack.

---
 rtl/mips_ras_pkg.sv | 22 ++
 rtl/mips_ras_undo.sv | 40 ++++
 rtl/mips_ras.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mips_ras_pkg.sv
// Shared definitions for the return-address stack: default depth, op encoding and
// the MIPS call/return decode constants used by the IF-stage caller.
package mips_ras_pkg;

  localparam int unsigned RasDepthDefault = 8;

  typedef enum logic [1:0] {
    RasOpNone    = 2'b00,
    RasOpPop     = 2'b01,
    RasOpPush    = 2'b10,
    RasOpPushPop = 2'b11
  } ras_op_e;

  localparam logic [5:0] FuncJr    = 6'h08;
  localparam logic [5:0] FuncJalr  = 6'h09;
  localparam logic [5:0] OpcodeJal = 6'h03;

  function automatic ras_op_e ras_op(input logic push, input logic pop);
    return ras_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/mips_ras_undo.sv
// One-deep undo record for the RAS: prior pointer/count plus the entry a stack op
// overwrote, so a squash from ID can roll back the youngest speculative op.
module mips_ras_undo #(
  parameter int unsigned PTR_WIDTH  = 3,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture,
  input  logic [PTR_WIDTH-1:0]  cap_tos,
  input  logic [PTR_WIDTH:0]    cap_count,
  input  logic [PTR_WIDTH-1:0]  cap_idx,
  input  logic [ADDR_WIDTH-1:0] cap_data,
  output logic                  valid,
  output logic [PTR_WIDTH-1:0]  tos,
  output logic [PTR_WIDTH:0]    count,
  output logic [PTR_WIDTH-1:0]  idx,
  output logic [ADDR_WIDTH-1:0] data
);

  // Any cycle that does not capture (idle or squash) retires the record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      tos   <= '0;
      count <= '0;
      idx   <= '0;
      data  <= '0;
    end else begin
      valid <= capture;
      if (capture) begin
        tos   <= cap_tos;
        count <= cap_count;
        idx   <= cap_idx;
        data  <= cap_data;
      end
    end
  end

endmodule

// File: rtl/mips_ras.sv
// Return-address stack predicting JR $31 targets in IF; circular buffer with
// wrap-around overwrite and single-op undo for squashes from ID.
module mips_ras
  import mips_ras_pkg::*;
#(
  parameter int unsigned DEPTH      = RasDepthDefault,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [ADDR_WIDTH-1:0] push_addr_i,
  input  logic                  pop_i,
  input  logic                  squash_i,
  output logic                  pred_valid_o,
  output logic [ADDR_WIDTH-1:0] pred_addr_o,
  output logic [PTR_WIDTH:0]    count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam logic [PTR_WIDTH:0] CountMax = (PTR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]  tos_q, tos_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  mem_we;
  logic [PTR_WIDTH-1:0]  mem_idx;
  logic [ADDR_WIDTH-1:0] mem_wdata;

  logic                  undo_valid;
  logic [PTR_WIDTH-1:0]  undo_tos;
  logic [PTR_WIDTH:0]    undo_count;
  logic [PTR_WIDTH-1:0]  undo_idx;
  logic [ADDR_WIDTH-1:0] undo_data;

  ras_op_e op;
  logic    empty;
  logic    push_like;
  logic    capture;

  assign op        = ras_op(push_i, pop_i);
  assign empty     = (count_q == '0);
  // A push+pop on an empty stack behaves as a plain push.
  assign push_like = (op == RasOpPush) || (op == RasOpPushPop && empty);
  assign capture   = (push_i | pop_i) & ~squash_i;

  always_comb begin
    tos_d       = tos_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    mem_idx     = tos_q + 1'b1;
    mem_wdata   = push_addr_i;
    if (squash_i) begin
      if (undo_valid) begin
        tos_d     = undo_tos;
        count_d   = undo_count;
        mem_we    = 1'b1;
        mem_idx   = undo_idx;
        mem_wdata = undo_data;
      end
    end else if (push_like) begin
      tos_d  = tos_q + 1'b1;
      mem_we = 1'b1;
      if (count_q == CountMax) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (op == RasOpPushPop) begin
      mem_we  = 1'b1;
      mem_idx = tos_q;
    end else if (op == RasOpPop) begin
      if (empty) begin
        underflow_d = 1'b1;
      end else begin
        tos_d   = tos_q - 1'b1;
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tos_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      tos_q       <= tos_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

  // Record the slot this op may write; a pop restores an untouched slot, which is harmless.
  mips_ras_undo #(
    .PTR_WIDTH  (PTR_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_undo (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .cap_tos   (tos_q),
    .cap_count (count_q),
    .cap_idx   (mem_idx),
    .cap_data  (mem_q[mem_idx]),
    .valid     (undo_valid),
    .tos       (undo_tos),
    .count     (undo_count),
    .idx       (undo_idx),
    .data      (undo_data)
  );

  assign pred_valid_o = ~empty;
  assign pred_addr_o  = mem_q[tos_q];
  assign count_o      = count_q;
  assign overflow_o   = overflow_q;
  assign underflow_o  = underflow_q;

endmodule
